xmpl_dsp: RTL
=============

XMPL_DSP -- requirements
Module: xmpl_dsp

Interface
REQ-001 SHALL have no parameters; all widths fixed as listed.
REQ-002 SHALL have ports: clk_i  in  1  sole clock, rising edge.
REQ-003 SHALL have ports: reset_i  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: dsp_cic_a12_i  in  12  signed CIC input sample.
REQ-005 SHALL have ports: dsp_cic_b15_i  in  15  unsigned decimation ratio R (0 treated as 1).
REQ-006 SHALL have ports: dsp_cic_c32_o  out  32  signed CIC decimated output.
REQ-007 SHALL have ports: dsp_fft_a2_i  in  2  sample-buffer write address.
REQ-008 SHALL have ports: dsp_fft_b4_i  in  4  signed sample.
REQ-009 SHALL have ports: dsp_fft_c16_o  out  16  signed DC bin.
REQ-010 SHALL have ports: dsp_flt_a7_i  in  7  signed coefficient.
REQ-011 SHALL have ports: dsp_flt_b8_i  in  8  signed sample.
REQ-012 SHALL have ports: dsp_flt_c23_o  out  23  signed MAC result.
REQ-013 SHALL have ports: dsp_en_fsm_i  in  1  sequencer enable from the RISC-V side.
REQ-014 SHALL have ports: dsp_fsm_state_o  out  14  sequencer status to the RISC-V side.

Function
REQ-015 Sequencer states SHALL be IDLE=0, CIC=1, FFT=2, FLT=3 (3-bit code).
REQ-016 IDLE->CIC SHALL occur on the first edge with dsp_en_fsm_i=1, cycle counter=0.
REQ-017 Phase lengths SHALL be CIC 16, FFT 4, FLT 8 cycles; order CIC->FFT->FLT->CIC while enabled.
REQ-018 Cycle counter SHALL count 0..len-1 per phase and reset to 0 on every phase change.
REQ-019 Pass counter (6 bit, wraps 63->0) SHALL increment on the FLT->CIC transition.
REQ-020 dsp_en_fsm_i=0 in any active state SHALL force IDLE on the next edge; cycle counter->0, pass counter held.
REQ-021 dsp_fsm_state_o SHALL be registered {state[2:0], pass[5:0], cycle[4:0]}, bits 13:11, 10:5, 4:0.
REQ-022 Each engine SHALL update only during its own phase; all outputs hold in other phases and IDLE.
REQ-023 CIC: each CIC cycle, 32-bit integrator += sign-extended a12 (two's-complement wrap) and decimation counter increments.
REQ-024 CIC: when decimation counter reaches max(R,1), c32 SHALL become integrator(new) minus integrator at previous dump, same edge; counter->0.
REQ-025 Integrator, dump register and decimation counter SHALL persist across phases and IDLE.
REQ-026 A change of R SHALL take effect on the next comparison; counter >= new R SHALL dump immediately.
REQ-027 FFT: each FFT cycle, buffer[a2] <= b4; c16 SHALL be the registered sum of the four sign-extended entries including that cycle's write (1-cycle latency).
REQ-028 FLT: accumulator SHALL clear on FLT entry; each FLT cycle acc += a7*b8 (signed 15-bit product); c23 <= acc each FLT cycle.
REQ-029 FLT width SHALL be sufficient (8*8192 < 2^22); no saturation logic.

Reset
REQ-030 Reset SHALL force state IDLE; counters, integrator, dump register, FFT buffer, FLT accumulator and all outputs to 0.
REQ-031 Reset asserted mid-phase SHALL abandon the phase; after release the sequencer SHALL restart at IDLE.

Structure
REQ-032 A shared package xmpl_dsp_pkg SHALL hold the state enum, phase-length constants and status-field offsets; the RISC-V side decodes status with it.
REQ-033 The CIC integrator/comb SHALL be a sub-module xmpl_dsp_cic; FFT and FLT stay inline.

Verification
REQ-034 Reset: assert reset_i mid-FFT -> all outputs 0 asynchronously; after release, en=1 -> state CIC next edge.
REQ-035 CIC: en=1, a12=1, R=4 -> c32=4 after CIC cycles 3,7,11,15; status at FFT entry = 0x1000 (state 2, pass 0, cycle 0).
REQ-036 FFT: b4=0xF, a2 cycling 0..3 -> c16=0xFFFC after last FFT cycle; holds through FLT.
REQ-037 FLT: a7=63, b8=127 for 8 cycles -> c23=64008 (0x00FA08); next pass restarts from 8001; pass field=1 at CIC re-entry.
REQ-038 R=0, a12=-2 -> c32=-2 every CIC cycle; R changed 8->2 when counter=5 -> dump on next CIC cycle.
REQ-039 Drop en at CIC cycle 9 -> IDLE next edge, cycle=0, pass held, outputs frozen; re-enable -> CIC cycle 0, integrator continues.

Source files
------------

// File: rtl/xmpl_dsp_pkg.sv
// Shared sequencer definitions: state codes, phase lengths and status-word layout.
// The RISC-V side decodes dsp_fsm_state_o with the same offsets.
package xmpl_dsp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CIC  = 3'd1,
    ST_FFT  = 3'd2,
    ST_FLT  = 3'd3
  } state_t;

  localparam logic [4:0] CIC_LEN = 5'd16;
  localparam logic [4:0] FFT_LEN = 5'd4;
  localparam logic [4:0] FLT_LEN = 5'd8;

  localparam int STAT_STATE_LSB = 11;
  localparam int STAT_PASS_LSB  = 5;
  localparam int STAT_CYCLE_LSB = 0;

  function automatic logic [4:0] phase_last(state_t s);
    case (s)
      ST_CIC:  phase_last = CIC_LEN - 5'd1;
      ST_FFT:  phase_last = FFT_LEN - 5'd1;
      ST_FLT:  phase_last = FLT_LEN - 5'd1;
      default: phase_last = 5'd0;
    endcase
  endfunction

  function automatic logic [13:0] pack_status(state_t s, logic [5:0] pass, logic [4:0] cyc);
    pack_status = (14'(s) << STAT_STATE_LSB) | (14'(pass) << STAT_PASS_LSB)
                | (14'(cyc) << STAT_CYCLE_LSB);
  endfunction

endpackage

// File: rtl/xmpl_dsp_cic.sv
// Single-stage CIC integrator/comb decimator; dump result registered on the decimating edge.
// No backpressure: advances on every cycle that 'active' is high, holds all state otherwise.
module xmpl_dsp_cic (
  input  logic        clk,
  input  logic        rst,
  input  logic        active,
  input  logic [11:0] sample,
  input  logic [14:0] ratio,
  output logic [31:0] dec_out
);

  logic [31:0] integ_q;
  logic [31:0] dump_q;
  logic [31:0] integ_n;
  logic [14:0] cnt_q;
  logic [14:0] cnt_n;
  logic [14:0] ratio_eff;
  logic        dump_now;

  // cnt_q never exceeds 32766, so the increment cannot overflow 15 bits.
  always_comb begin
    integ_n   = integ_q + {{20{sample[11]}}, sample};
    cnt_n     = cnt_q + 15'd1;
    ratio_eff = (ratio == 15'd0) ? 15'd1 : ratio;
    dump_now  = (cnt_n >= ratio_eff);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      integ_q <= '0;
      dump_q  <= '0;
      cnt_q   <= '0;
      dec_out <= '0;
    end else if (active) begin
      integ_q <= integ_n;
      if (dump_now) begin
        dec_out <= integ_n - dump_q;
        dump_q  <= integ_n;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_n;
      end
    end
  end

endmodule

// File: rtl/xmpl_dsp.sv
// Phase sequencer (IDLE/CIC/FFT/FLT) time-sharing three small DSP engines; status registered.
// No backpressure: each engine advances one step per cycle of its phase, outputs hold otherwise.
module xmpl_dsp
  import xmpl_dsp_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [11:0] dsp_cic_a12_i,
  input  logic [14:0] dsp_cic_b15_i,
  output logic [31:0] dsp_cic_c32_o,
  input  logic [1:0]  dsp_fft_a2_i,
  input  logic [3:0]  dsp_fft_b4_i,
  output logic [15:0] dsp_fft_c16_o,
  input  logic [6:0]  dsp_flt_a7_i,
  input  logic [7:0]  dsp_flt_b8_i,
  output logic [22:0] dsp_flt_c23_o,
  input  logic        dsp_en_fsm_i,
  output logic [13:0] dsp_fsm_state_o
);

  state_t      state_q, state_n;
  logic [4:0]  cycle_q, cycle_n;
  logic [5:0]  pass_q, pass_n;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q         <= ST_IDLE;
      cycle_q         <= '0;
      pass_q          <= '0;
      dsp_fsm_state_o <= '0;
    end else begin
      state_q         <= state_n;
      cycle_q         <= cycle_n;
      pass_q          <= pass_n;
      dsp_fsm_state_o <= pack_status(state_n, pass_n, cycle_n);
    end
  end

  always_comb begin
    state_n = state_q;
    cycle_n = cycle_q;
    pass_n  = pass_q;
    if (state_q == ST_IDLE) begin
      if (dsp_en_fsm_i) begin
        state_n = ST_CIC;
        cycle_n = '0;
      end
    end else if (!dsp_en_fsm_i) begin
      state_n = ST_IDLE;
      cycle_n = '0;
    end else if (cycle_q == phase_last(state_q)) begin
      cycle_n = '0;
      case (state_q)
        ST_CIC:  state_n = ST_FFT;
        ST_FFT:  state_n = ST_FLT;
        ST_FLT: begin
          state_n = ST_CIC;
          pass_n  = pass_q + 6'd1;
        end
        default: state_n = ST_IDLE;
      endcase
    end else begin
      cycle_n = cycle_q + 5'd1;
    end
  end

  xmpl_dsp_cic u_cic (
    .clk     (clk_i),
    .rst     (reset_i),
    .active  (state_q == ST_CIC),
    .sample  (dsp_cic_a12_i),
    .ratio   (dsp_cic_b15_i),
    .dec_out (dsp_cic_c32_o)
  );

  // FFT DC bin: the sum sees this cycle's write as if already stored.
  logic [3:0]  fft_buf [4];
  logic [3:0]  fft_ent;
  logic [15:0] fft_sum;

  always_comb begin
    fft_ent = '0;
    fft_sum = '0;
    for (int i = 0; i < 4; i++) begin
      fft_ent = (2'(i) == dsp_fft_a2_i) ? dsp_fft_b4_i : fft_buf[i];
      fft_sum = fft_sum + {{12{fft_ent[3]}}, fft_ent};
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < 4; i++) fft_buf[i] <= '0;
      dsp_fft_c16_o <= '0;
    end else if (state_q == ST_FFT) begin
      fft_buf[dsp_fft_a2_i] <= dsp_fft_b4_i;
      dsp_fft_c16_o         <= fft_sum;
    end
  end

  logic signed [14:0] flt_prod;
  logic [22:0]        flt_acc_q;
  logic [22:0]        flt_acc_n;

  always_comb begin
    flt_prod  = $signed({{8{dsp_flt_a7_i[6]}}, dsp_flt_a7_i})
              * $signed({{7{dsp_flt_b8_i[7]}}, dsp_flt_b8_i});
    flt_acc_n = flt_acc_q + {{8{flt_prod[14]}}, flt_prod};
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      flt_acc_q     <= '0;
      dsp_flt_c23_o <= '0;
    end else if (state_q == ST_FLT) begin
      flt_acc_q     <= flt_acc_n;
      dsp_flt_c23_o <= flt_acc_n;
    end else if (state_n == ST_FLT) begin
      flt_acc_q <= '0;
    end
  end

endmodule
